// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the memory arbiter's state and grant-kind enums.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_READ  = 2'd1,
    GRANT_WRITE = 2'd2
  } grant_kind_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one shared memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data priority with a starvation guard.
module mem_arbiter
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic [15:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_byte_enable,
  output logic [15:0] d_rdata,
  output logic        d_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  arb_state_t    state, next_state;
  grant_kind_t   grant_kind;
  lc3b_word      grant_addr;
  lc3b_word      grant_wdata;
  lc3b_mem_wmask grant_be;
  logic          d_req;
  logic          grant_i;
  logic          grant_d;

`ifdef MEM_ARB_RR_EN
  logic          last_d;
`else
  logic [1:0]    starve_cnt;
`endif

  assign d_req = d_read | d_write;

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    unique case (state)
      IDLE: begin
`ifdef MEM_ARB_RR_EN
        if (d_req && i_read) begin
          grant_d = ~last_d;
          grant_i = last_d;
        end else begin
          grant_d = d_req;
          grant_i = i_read;
        end
`else
        // Starvation guard overrides the fixed data priority.
        if (i_read && starve_cnt == 2'd3)
          grant_i = 1'b1;
        else if (d_req)
          grant_d = 1'b1;
        else if (i_read)
          grant_i = 1'b1;
`endif
        if (grant_d)
          next_state = SERVE_D;
        else if (grant_i)
          next_state = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_kind  <= GRANT_NONE;
      grant_addr  <= '0;
      grant_wdata <= '0;
      grant_be    <= '0;
`ifdef MEM_ARB_RR_EN
      last_d      <= 1'b0;
`else
      starve_cnt  <= '0;
`endif
    end else begin
      state <= next_state;
      if (grant_d) begin
        grant_addr  <= d_address;
        grant_wdata <= d_wdata;
        grant_be    <= d_byte_enable;
        grant_kind  <= d_write ? GRANT_WRITE : GRANT_READ;
      end else if (grant_i) begin
        grant_addr  <= i_address;
        grant_wdata <= '0;
        grant_be    <= '1;
        grant_kind  <= GRANT_READ;
      end
`ifdef MEM_ARB_RR_EN
      if (grant_d)
        last_d <= 1'b1;
      else if (grant_i)
        last_d <= 1'b0;
`else
      if (grant_i)
        starve_cnt <= '0;
      else if (grant_d && i_read && starve_cnt != 2'd3)
        starve_cnt <= starve_cnt + 2'd1;
`endif
    end
  end

  // Strobes come only from the latched grant; address/data/mask hold while idle.
  assign pmem_read        = (state != IDLE) && (grant_kind == GRANT_READ);
  assign pmem_write       = (state != IDLE) && (grant_kind == GRANT_WRITE);
  assign pmem_address     = grant_addr;
  assign pmem_wdata       = grant_wdata;
  assign pmem_byte_enable = grant_be;

  assign i_resp  = pmem_resp & (state == SERVE_I);
  assign d_resp  = pmem_resp & (state == SERVE_D);
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed scenarios.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_read = 1'b0;
  logic [15:0] i_address = '0;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [15:0] d_address = '0;
  logic [15:0] d_wdata = '0;
  logic [1:0]  d_byte_enable = '0;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;
  logic        resp_gen = 1'b0;
  logic        resp_extra = 1'b0;

  int checks = 0;
  int failures = 0;
  int lat = 3;
  int wcnt = 0;
  int n_iresp = 0;
  int n_dresp = 0;
  bit cmp_en = 1'b0;
  string seq = "";

  // Transaction-level model of the arbiter.
  bit          m_busy = 1'b0;
  bit          m_port_d = 1'b0;
  bit          m_write = 1'b0;
  bit          m_wdata_known = 1'b1;
  bit          m_last_d = 1'b0;
  int          m_starve = 0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [1:0]  m_be = '0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  assign pmem_rdata = pmem_address ^ 16'hAEEF;
  assign pmem_resp  = resp_gen | resp_extra;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%s expected=%s", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input bit want_d, output int waited);
    waited = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      waited++;
      if (want_d ? d_resp : i_resp) return;
    end
    chk(want_d ? "d_resp_timeout" : "i_resp_timeout", 32'd0, 32'd1);
  endtask

  // Memory responder: pulses pmem_resp in the lat-th strobe cycle.
  always @(posedge clk) begin
    #2;
    if (resp_gen) begin
      resp_gen = 1'b0;
      wcnt = 0;
    end else if (pmem_read || pmem_write) begin
      wcnt++;
      if (wcnt >= lat) begin
        resp_gen = 1'b1;
        wcnt = 0;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(posedge clk) begin
    bit gd;
    bit gi;
    gd = 1'b0;
    gi = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0; m_write = 1'b0;
      m_wdata_known = 1'b1; m_starve = 0; m_last_d = 1'b0;
    end else if (m_busy) begin
      if (pmem_resp) m_busy = 1'b0;
    end else begin
`ifdef MEM_ARB_RR_EN
      if ((d_read || d_write) && i_read) begin gd = !m_last_d; gi = m_last_d; end
      else begin gd = d_read || d_write; gi = i_read; end
`else
      if (i_read && m_starve == 3) gi = 1'b1;
      else if (d_read || d_write) gd = 1'b1;
      else if (i_read) gi = 1'b1;
`endif
      if (gd) begin
        m_busy = 1'b1; m_port_d = 1'b1; m_addr = d_address; m_wdata = d_wdata;
        m_wdata_known = 1'b1; m_be = d_byte_enable; m_write = d_write; m_last_d = 1'b1;
        if (i_read && m_starve < 3) m_starve++;
      end else if (gi) begin
        m_busy = 1'b1; m_port_d = 1'b0; m_addr = i_address; m_wdata_known = 1'b0;
        m_be = 2'b11; m_write = 1'b0; m_last_d = 1'b0; m_starve = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pmem_read", pmem_read, m_busy && !m_write);
      chk("pmem_write", pmem_write, m_busy && m_write);
      chk("pmem_address", pmem_address, m_addr);
      chk("pmem_byte_enable", pmem_byte_enable, m_be);
      if (m_wdata_known) chk("pmem_wdata", pmem_wdata, m_wdata);
      chk("i_resp", i_resp, m_busy && !m_port_d && pmem_resp);
      chk("d_resp", d_resp, m_busy && m_port_d && pmem_resp);
      chk("i_rdata", i_rdata, m_addr ^ 16'hAEEF);
      chk("d_rdata", d_rdata, m_addr ^ 16'hAEEF);
    end
    if (i_resp) begin n_iresp++; seq = {seq, "I"}; end
    if (d_resp) begin n_dresp++; seq = {seq, "D"}; end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int bi;
    int bd;
    string exp_seq;

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_pmem_be", pmem_byte_enable, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    cmp_en = 1'b1;
    step();
    rst = 1'b0;

    // Single instruction read with three-cycle memory latency
    lat = 3;
    step();
    bi = n_iresp; bd = n_dresp;
    i_read = 1'b1; i_address = 16'h1000;
    @(negedge clk);
    chk("n_idle_before_grant", pmem_read, 0);
    step();
    i_read = 1'b0;
    @(negedge clk);
    chk("n1_pmem_read", pmem_read, 1);
    chk("n1_pmem_address", pmem_address, 16'h1000);
    chk("n1_pmem_be", pmem_byte_enable, 2'b11);
    wait_resp(1'b0, w);
    chk("i_resp_latency", w, 2);
    chk("i_rdata_beef", i_rdata, 16'hBEEF);
    repeat (4) step();
    chk("i_resp_count", n_iresp - bi, 1);
    chk("d_resp_none", n_dresp - bd, 0);

    // Simultaneous I read and D write: data first
    bi = n_iresp; bd = n_dresp;
    d_write = 1'b1; d_address = 16'h2001; d_wdata = 16'h00AB; d_byte_enable = 2'b10;
    i_read = 1'b1; i_address = 16'h1100;
    step();
    @(negedge clk);
    chk("contend_d_write", pmem_write, 1);
    chk("contend_d_addr", pmem_address, 16'h2001);
    chk("contend_d_mask", pmem_byte_enable, 2'b10);
    chk("contend_d_wdata", pmem_wdata, 16'h00AB);
    wait_resp(1'b1, w);
    step();
    d_write = 1'b0;
    @(negedge clk);
    chk("gap_idle_read", pmem_read, 0);
    chk("gap_idle_write", pmem_write, 0);
    wait_resp(1'b0, w);
    step();
    i_read = 1'b0;
    repeat (3) step();
    chk("contend_i_count", n_iresp - bi, 1);
    chk("contend_d_count", n_dresp - bd, 1);

    // Continuous contention from reset
    rst = 1'b1; step(); rst = 1'b0;
    lat = 1;
    seq = "";
    d_read = 1'b1; d_address = 16'h5000;
    i_read = 1'b1; i_address = 16'h6000;
    for (int c = 0; c < 200; c++) begin
      step();
      if (seq.len() >= 8) break;
    end
    d_read = 1'b0; i_read = 1'b0;
    repeat (6) step();
`ifdef MEM_ARB_RR_EN
    exp_seq = "DIDIDIDI";
`else
    exp_seq = "DDDIDDDI";
`endif
    if (seq.len() >= 8) chk_str("grant_sequence", seq.substr(0, 7), exp_seq);
    else chk_str("grant_sequence", seq, exp_seq);

    // Address change during SERVE_D does not reach pmem
    lat = 4;
    bd = n_dresp;
    d_read = 1'b1; d_address = 16'h3000;
    step();
    d_address = 16'h4000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("hold_addr_3000", pmem_address, 16'h3000);
      if (d_resp) break;
    end
    step();
    d_read = 1'b0;
    repeat (3) step();
    chk("hold_d_count", n_dresp - bd, 1);

    // Reset mid-SERVE_I abandons the access
    lat = 8;
    bi = n_iresp;
    i_read = 1'b1; i_address = 16'h1234;
    step();
    i_read = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_pmem_read", pmem_read, 0);
    chk("rst_mid_addr", pmem_address, 0);
    repeat (10) step();
    chk("rst_mid_no_i_resp", n_iresp - bi, 0);

    // Stray pmem_resp while idle
    bi = n_iresp; bd = n_dresp;
    resp_extra = 1'b1;
    @(negedge clk);
    chk("idle_resp_i", i_resp, 0);
    chk("idle_resp_d", d_resp, 0);
    step();
    resp_extra = 1'b0;
    repeat (3) step();
    chk("idle_resp_counts", (n_iresp - bi) + (n_dresp - bd), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
